// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART arbiters: FSM state encoding and
// parameter defaults used by the TX arbiter and its round-robin picker.
package uart_arb_pkg;

    localparam int NUM_REQ_DEF      = 4;
    localparam int BUSY_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ. Shared between the TX and RX arbiters.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // Scanning from the far end leaves the nearest request to ptr as the final assignment.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                valid  = 1'b1;
                winner = IDX_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one asynchronous UART transmitter among NUM_REQ byte streams,
// keeping each packet contiguous and rotating ownership round-robin.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] data,
    input  logic [NUM_REQ-1:0]   last,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 tx_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_err_q, tx_err_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [IDX_W-1:0]   owner_inc;
    logic [IDX_W-1:0]   load_idx;
    logic               load_en;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign load_idx  = (state_q == ST_HOLD) ? owner_q : pick_idx;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_err_d   = 1'b0;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        load_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                load_en = pick_valid && !tx_busy;
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    tx_err_d = 1'b1;
                    grant_d  = '0;
                    ptr_d    = owner_inc;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = owner_inc;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                load_en = req[owner_q];
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // The start strobe and ack are registered here so they appear together in LOAD.
        if (load_en) begin
            owner_d           = load_idx;
            grant_d           = '0;
            grant_d[load_idx] = 1'b1;
            ack_d[load_idx]   = 1'b1;
            tx_start_d        = 1'b1;
            tx_data_d         = data[{load_idx, 3'b000} +: 8];
            last_d            = last[load_idx];
            state_d           = ST_LOAD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_err_q   <= 1'b0;
            ptr_q      <= '0;
            owner_q    <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_err_q   <= tx_err_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack      = ack_q;
    assign grant    = grant_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a transmitter model
// advance once per falling edge; a scoreboard checks each started byte.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int BUSY_LEN = 4;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] b;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [8*N-1:0] data;
    logic [N-1:0]  last;
    logic [N-1:0]  ack;
    logic [N-1:0]  grant;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          tx_err;

    int checks = 0;
    int errors = 0;

    exp_t       exp_q[$];
    logic [8:0] rq_mem [N][16];
    logic [3:0] rd_p [N];
    logic [3:0] wr_p [N];
    int         busy_cnt   = 0;
    bit         busy_force = 0;
    bit         model_en   = 1;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data     (data),
        .last     (last),
        .ack      (ack),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_err   (tx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++)
            if (rd_p[i] != wr_p[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One cycle: transmitter model, scoreboard, protocol monitors, requesters.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (tx_start === 1'b1 && model_en) begin
            busy_cnt = BUSY_LEN;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got grant=%b data=%h", grant, tx_data);
            end else begin
                e = exp_q.pop_front();
                if (grant !== (4'b1 << e.idx) || ack !== (4'b1 << e.idx) || tx_data !== e.b) begin
                    errors++;
                    $display("FAIL sb_byte got grant=%b ack=%b data=%h want owner=%0d data=%h",
                             grant, ack, tx_data, e.idx, e.b);
                end
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = busy_force || (busy_cnt != 0);

        checks++;
        if (!$onehot0(grant)) begin
            errors++;
            $display("FAIL grant_onehot got %b want one-hot or zero", grant);
        end
        checks++;
        if (ack !== 4'b0 && (tx_start !== 1'b1 || ack !== grant)) begin
            errors++;
            $display("FAIL ack_scope got ack=%b tx_start=%b grant=%b want ack only with tx_start to owner",
                     ack, tx_start, grant);
        end

        for (int i = 0; i < N; i++) begin
            if (ack[i] === 1'b1 && rd_p[i] != wr_p[i]) rd_p[i]++;
            req[i]         = (rd_p[i] != wr_p[i]);
            data[i*8 +: 8] = rq_mem[i][rd_p[i]][7:0];
            last[i]        = rq_mem[i][rd_p[i]][8];
        end
    endtask

    task automatic push_exp(input int i, input logic [7:0] b);
        exp_t e;
        e.idx = 2'(i);
        e.b   = b;
        exp_q.push_back(e);
    endtask

    task automatic send(input int i, input logic [7:0] b, input logic l, input bit expect_it);
        rq_mem[i][wr_p[i]] = {l, b};
        wr_p[i]++;
        if (expect_it) push_exp(i, b);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        exp_q.delete();
        busy_cnt   = 0;
        busy_force = 0;
        model_en   = 1;
        tx_busy    = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_p[i] = '0;
            wr_p[i] = '0;
            for (int j = 0; j < 16; j++) rq_mem[i][j] = '0;
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain(input int max, input string name);
        int n = 0;
        bit done = 0;
        while (!done && n < max) begin
            step();
            n++;
            done = (exp_q.size() == 0) && (grant === 4'b0) && (tx_busy === 1'b0) && queues_empty();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain got pending=%0d grant=%b want all bytes sent and grant=0000",
                     name, exp_q.size(), grant);
        end
    endtask

    task automatic wait_start(input int max, input string name);
        int n = 0;
        while (tx_start !== 1'b1 && n < max) begin
            step();
            n++;
        end
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL %s_start got tx_start=%b want 1 within %0d cycles", name, tx_start, max);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = '0;
        data    = '0;
        last    = '0;
        tx_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_p[i] = '0;
            wr_p[i] = '0;
            for (int j = 0; j < 16; j++) rq_mem[i][j] = '0;
        end
        step();
        checks++;
        if ({grant, ack, tx_start, tx_data, tx_err} !== 17'b0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b ack=%b start=%b data=%h err=%b want all zero",
                     grant, ack, tx_start, tx_data, tx_err);
        end
    endtask

    task automatic test_single_byte();
        reset_dut();
        send(2, 8'hA5, 1'b1, 1'b1);
        step();
        checks++;
        if (tx_start !== 1'b0 || grant !== 4'b0) begin
            errors++;
            $display("FAIL single_early got start=%b grant=%b want 0 and 0000", tx_start, grant);
        end
        step();
        checks++;
        if (tx_start !== 1'b1 || ack !== 4'b0100 || grant !== 4'b0100 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_load got start=%b ack=%b grant=%b data=%h want 1 0100 0100 a5",
                     tx_start, ack, grant, tx_data);
        end
        step();
        checks++;
        if (tx_start !== 1'b0 || ack !== 4'b0 || grant !== 4'b0100 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_after got start=%b ack=%b grant=%b data=%h want 0 0000 0100 a5",
                     tx_start, ack, grant, tx_data);
        end
        drain(100, "single");
    endtask

    task automatic test_round_robin();
        reset_dut();
        send(0, 8'h10, 1'b1, 1'b1);
        send(1, 8'h11, 1'b1, 1'b1);
        send(2, 8'h12, 1'b1, 1'b1);
        send(3, 8'h13, 1'b1, 1'b1);
        send(0, 8'h20, 1'b1, 1'b1);
        drain(300, "rr");
    endtask

    task automatic test_packet();
        reset_dut();
        send(1, 8'h01, 1'b0, 1'b1);
        send(1, 8'h02, 1'b0, 1'b1);
        send(1, 8'h03, 1'b1, 1'b1);
        wait_start(10, "packet");
        send(0, 8'h0A, 1'b1, 1'b1);
        drain(300, "packet");
    endtask

    task automatic test_hold();
        int n = 0;
        bit bad = 0;
        reset_dut();
        send(2, 8'hB1, 1'b0, 1'b1);
        while (!(exp_q.size() == 0 && tx_busy === 1'b0 && busy_cnt == 0) && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL hold_enter got grant=%b want 0100", grant);
        end
        send(3, 8'hC3, 1'b1, 1'b0);
        send(0, 8'hD0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step();
            if (grant !== 4'b0100 || tx_start !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_ignore got a start or grant change during hold, want grant=0100 and no start");
        end
        send(2, 8'hB2, 1'b1, 1'b1);
        push_exp(3, 8'hC3);
        push_exp(0, 8'hD0);
        drain(300, "hold");
    endtask

    task automatic test_timeout();
        int k = 0;
        reset_dut();
        model_en = 0;
        send(3, 8'hE3, 1'b1, 1'b0);
        wait_start(10, "timeout");
        while (tx_err !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (k != 16) begin
            errors++;
            $display("FAIL timeout_delay got %0d cycles want 16", k);
        end
        checks++;
        if (grant !== 4'b0) begin
            errors++;
            $display("FAIL timeout_grant got %b want 0000", grant);
        end
        step();
        checks++;
        if (tx_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse got tx_err=%b want 0 after one cycle", tx_err);
        end
        model_en = 1;
        send(0, 8'hF0, 1'b1, 1'b1);
        send(3, 8'hF3, 1'b1, 1'b1);
        drain(200, "timeout_ptr");
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        reset_dut();
        send(1, 8'h77, 1'b1, 1'b1);
        wait_start(10, "rstmid");
        step();
        step();
        busy_force = 1;
        send(2, 8'h88, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, ack, tx_start, tx_data, tx_err} !== 17'b0) begin
            errors++;
            $display("FAIL rstmid_outputs got grant=%b ack=%b start=%b data=%h err=%b want all zero",
                     grant, ack, tx_start, tx_data, tx_err);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_start !== 1'b0 || grant !== 4'b0 || ack !== 4'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rstmid_block got a start/grant/ack while tx_busy=1, want none");
        end
        busy_force = 0;
        drain(100, "rstmid");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet();
        test_hold();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
